// File: rtl/complex_nr_op_loader_pkg.sv
// Shared definitions for the complex-multiplier operand loader: FSM encoding and word-slot indices.
package cnr_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] A_RE = 2'd0;
  localparam logic [1:0] A_IM = 2'd1;
  localparam logic [1:0] B_RE = 2'd2;
  localparam logic [1:0] B_IM = 2'd3;
endpackage

// File: rtl/complex_nr_op_loader_out_reg.sv
// Valid/ready holding register with a load port; 1-cycle load-to-valid, data frozen while stalled.
// free means a load is allowed this cycle (empty, or draining in the same cycle).
module cnr_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sw_rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         out_val,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         free
);
  assign free = !out_val || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (sw_rst) begin
      out_val  <= 1'b0;
      out_data <= '0;
    end else if (load) begin
      out_val  <= 1'b1;
      out_data <= load_data;
    end else if (out_val && out_ready) begin
      out_val  <= 1'b0;
    end
  end
endmodule

// File: rtl/complex_nr_op_loader.sv
// Packs 4-word serial frames {a_re,a_im,b_re,b_im} into one operand for the complex multiplier.
// Operand valid 1 cycle after b_im; one frame buffered in HOLD, in_ready registered (no op_ready path).
module complex_nr_op_loader
  import cnr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sw_rst,
  input  logic                    in_val,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_sof,
  output logic                    op_val,
  input  logic                    op_ready,
  output logic [4*DATA_WIDTH-1:0] op_data,
  output logic                    frame_err,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);
  localparam int OW = 4 * DATA_WIDTH;

  state_t                         state, state_nxt;
  logic [1:0]                     idx, idx_nxt;
  logic [3:0][DATA_WIDTH-1:0]     words;
  logic                           accept;
  logic                           wr_en;
  logic [1:0]                     wr_slot;
  logic                           load;
  logic [OW-1:0]                  load_data;
  logic                           err_set;
  logic                           out_free;

  assign in_ready = (state != HOLD);
  assign accept   = in_val && in_ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    wr_slot   = idx;
    load      = 1'b0;
    load_data = {words[A_RE], words[A_IM], words[B_RE], words[B_IM]};
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            wr_en     = 1'b1;
            wr_slot   = A_RE;
            idx_nxt   = A_IM;
            state_nxt = FILL;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // Resync: the new sof word restarts the frame.
            err_set = 1'b1;
            wr_slot = A_RE;
            idx_nxt = A_IM;
          end else if (idx == B_IM) begin
            idx_nxt = A_RE;
            if (out_free) begin
              // Bypass the buffer so the operand appears one cycle after b_im.
              load      = 1'b1;
              load_data = {words[A_RE], words[A_IM], words[B_RE], in_data};
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLD;
            end
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= A_RE;
      words     <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else if (sw_rst) begin
      state     <= IDLE;
      idx       <= A_RE;
      words     <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (wr_en) words[wr_slot] <= in_data;
      if (err_set) frame_err <= 1'b1;
      if (op_val && op_ready) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  cnr_out_reg #(.W(OW)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .sw_rst    (sw_rst),
    .load      (load),
    .load_data (load_data),
    .out_val   (op_val),
    .out_ready (op_ready),
    .out_data  (op_data),
    .free      (out_free)
  );
endmodule

// File: tb/tb_complex_nr_op_loader.sv
// Randomized bench for complex_nr_op_loader against a frame-level reference model.
module tb_complex_nr_op_loader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_rst;
  logic          in_val;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          op_val;
  logic          op_ready;
  logic [4*DW-1:0] op_data;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  logic rand_ready = 1'b0;

  logic [31:0] obs_q[$];
  int          obs_cyc[$];
  logic [31:0] exp_q[$];
  logic [7:0]  part[$];
  logic        m_err;
  int          m_total;

  complex_nr_op_loader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .sw_rst(sw_rst),
    .in_val(in_val), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
    .op_val(op_val), .op_ready(op_ready), .op_data(op_data),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records each handshake that will complete at the coming rising edge.
  always @(negedge clk) begin
    if (!rst && !sw_rst && op_val && op_ready) begin
      obs_q.push_back(op_data);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame-level reference: words collect into a list, sof restarts it, four words make an operand.
  task automatic model_word(input logic [7:0] d, input logic s);
    if (s) begin
      if (part.size() != 0) m_err = 1'b1;
      part.delete();
      part.push_back(d);
    end else if (part.size() == 0) begin
      m_err = 1'b1;
    end else begin
      part.push_back(d);
    end
    if (part.size() == 4) begin
      exp_q.push_back({part[0], part[1], part[2], part[3]});
      m_total++;
      part.delete();
    end
  endtask

  task automatic clear_model();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete(); part.delete();
    m_err = 1'b0; m_total = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) op_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input logic [7:0] d, input logic s);
    bit ok = 0;
    in_val = 1'b1; in_data = d; in_sof = s;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) begin
      asserts++; fails++;
      $display("FAIL send_word_timeout: word %h never accepted", d);
    end else begin
      model_word(d, s);
    end
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_word(f[31:24], 1'b1);
    send_word(f[23:16], 1'b0);
    send_word(f[15:8],  1'b0);
    send_word(f[7:0],   1'b0);
  endtask

  task automatic drain();
    in_val = 1'b0;
    for (int n = 0; n < 200 && obs_q.size() < exp_q.size(); n++) tick();
    tick();
  endtask

  task automatic do_sw_rst();
    in_val = 1'b0;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_rst = 1'b0; in_val = 1'b0; in_sof = 1'b0; in_data = '0; op_ready = 1'b0;
    clear_model();
    #12;
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    asserts++; if (op_val !== 1'b0) begin fails++; $display("FAIL reset_op_val: got %b want 0", op_val); end
    asserts++; if (op_data !== 32'h0) begin fails++; $display("FAIL reset_op_data: got %h want 0", op_data); end
    asserts++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    asserts++; if (frame_cnt !== '0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    do_sw_rst();
    op_ready = 1'b1;
    send_word(8'h03, 1'b1); send_word(8'h04, 1'b0);
    send_word(8'h05, 1'b0); send_word(8'h06, 1'b0);
    in_val = 1'b0;
    @(negedge clk);
    asserts++; if (op_val !== 1'b1) begin fails++; $display("FAIL single_latency: op_val %b want 1", op_val); end
    asserts++; if (op_data !== 32'h03040506) begin fails++; $display("FAIL single_data: got %h want 03040506", op_data); end
    tick();
    @(negedge clk);
    asserts++; if (frame_cnt !== CW'(1)) begin fails++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
    asserts++; if (op_val !== 1'b0) begin fails++; $display("FAIL single_drop: op_val %b want 0", op_val); end
    asserts++; if (obs_q.size() != 1) begin fails++; $display("FAIL single_count: got %0d transfers want 1", obs_q.size()); end
  endtask

  task automatic test_backpressure();
    do_sw_rst();
    op_ready = 1'b0;
    send_frame(32'h01020304);
    send_frame(32'h05060708);
    in_val = 1'b0;
    @(negedge clk);
    asserts++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready: got %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      asserts++;
      if (op_val !== 1'b1 || op_data !== 32'h01020304) begin
        fails++; $display("FAIL bp_stable[%0d]: val %b data %h want 1 01020304", i, op_val, op_data);
      end
      tick();
      @(negedge clk);
    end
    tick();
    op_ready = 1'b1;
    drain();
    asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      asserts++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_order[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    asserts++; if (frame_cnt !== CW'(2)) begin fails++; $display("FAIL bp_cnt: got %0d want 2", frame_cnt); end
    asserts++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    do_sw_rst();
    op_ready = 1'b1;
    for (int f = 0; f < 8; f++) send_frame($urandom);
    drain();
    asserts++; if (obs_q.size() != 8) begin fails++; $display("FAIL stream_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      asserts++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL stream_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      if (i > 0) begin
        asserts++;
        if (obs_cyc[i] - obs_cyc[i-1] != 4) begin
          fails++; $display("FAIL stream_gap[%0d]: got %0d cycles want 4", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
    asserts++; if (frame_cnt !== CW'(8)) begin fails++; $display("FAIL stream_cnt: got %0d want 8", frame_cnt); end
  endtask

  task automatic test_resync();
    do_sw_rst();
    op_ready = 1'b1;
    send_word(8'h11, 1'b1); send_word(8'h22, 1'b0);
    send_frame(32'hA1A2A3A4);
    drain();
    asserts++; if (frame_err !== m_err) begin fails++; $display("FAIL resync_err: got %b want %b", frame_err, m_err); end
    asserts++; if (obs_q.size() != 1) begin fails++; $display("FAIL resync_count: got %0d want 1", obs_q.size()); end
    else begin
      asserts++; if (obs_q[0] !== 32'hA1A2A3A4) begin fails++; $display("FAIL resync_data: got %h want a1a2a3a4", obs_q[0]); end
    end
  endtask

  task automatic test_missing_sof();
    logic [31:0] f;
    do_sw_rst();
    op_ready = 1'b1;
    send_word(8'h55, 1'b0);
    idle(2);
    @(negedge clk);
    asserts++; if (frame_err !== 1'b1) begin fails++; $display("FAIL nosof_err: got %b want 1", frame_err); end
    asserts++; if (op_val !== 1'b0) begin fails++; $display("FAIL nosof_discard: op_val %b want 0", op_val); end
    f = $urandom;
    send_frame(f);
    drain();
    asserts++; if (obs_q.size() != 1 || obs_q[0] !== f) begin
      fails++; $display("FAIL nosof_next: got %0d transfers first %h want 1 of %h", obs_q.size(), obs_q.size() ? obs_q[0] : 32'h0, f);
    end
  endtask

  task automatic test_reset_mid();
    do_sw_rst();
    op_ready = 1'b1;
    send_frame(32'hC1C2C3C4);
    drain();
    send_word(8'hD1, 1'b1); send_word(8'hD2, 1'b0);
    in_val = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    asserts++; if (in_ready !== 1'b1 || op_val !== 1'b0 || op_data !== 32'h0 || frame_cnt !== '0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL rst_mid: rdy %b val %b data %h cnt %0d err %b want 1 0 0 0 0", in_ready, op_val, op_data, frame_cnt, frame_err);
    end
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk);
      asserts++; if (op_val !== 1'b0) begin fails++; $display("FAIL rst_no_pulse[%0d]: op_val %b want 0", i, op_val); end
    end
    op_ready = 1'b0;
    send_frame(32'hE1E2E3E4);
    send_frame(32'hF1F2F3F4);
    in_val = 1'b0;
    @(negedge clk);
    asserts++; if (op_val !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL swrst_setup: val %b rdy %b want 1 0", op_val, in_ready); end
    obs_q.delete();
    op_ready = 1'b1;
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    @(negedge clk);
    asserts++; if (in_ready !== 1'b1 || op_val !== 1'b0 || op_data !== 32'h0 || frame_cnt !== '0 || frame_err !== 1'b0) begin
      fails++; $display("FAIL swrst_hold: rdy %b val %b data %h cnt %0d err %b want 1 0 0 0 0", in_ready, op_val, op_data, frame_cnt, frame_err);
    end
    idle(5);
    asserts++; if (obs_q.size() != 0 || frame_cnt !== '0) begin
      fails++; $display("FAIL swrst_lost: %0d transfers cnt %0d want 0 0", obs_q.size(), frame_cnt);
    end
    clear_model();
  endtask

  task automatic test_random();
    int k;
    do_sw_rst();
    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      if (k < 8) begin
        send_frame($urandom);
      end else if (k == 8) begin
        send_word(8'($urandom), 1'b0);
      end else begin
        send_word(8'($urandom), 1'b1);
        for (int j = 0; j < $urandom_range(0, 2); j++) send_word(8'($urandom), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    in_val = 1'b0;
    rand_ready = 1'b0;
    op_ready = 1'b1;
    drain();
    asserts++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      asserts++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand_data[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    asserts++; if (frame_err !== m_err) begin fails++; $display("FAIL rand_err: got %b want %b", frame_err, m_err); end
    asserts++; if (frame_cnt !== CW'(m_total)) begin fails++; $display("FAIL rand_cnt_wrap: got %0d want %0d", frame_cnt, m_total % (1 << CW)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_resync();
    test_missing_sof();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
